// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg
//   Shared definitions for the EX-stage multiply/divide unit and the decoder:
//   MDop one-hot bit positions, FSM state encodings and the MDop priority
//   decode.
package ex_muldiv_pkg;

   localparam int MD_MULT  = 0;
   localparam int MD_MULTU = 1;
   localparam int MD_DIV   = 2;
   localparam int MD_DIVU  = 3;
   localparam int MD_MFHI  = 4;
   localparam int MD_MFLO  = 5;
   localparam int MD_MTHI  = 6;
   localparam int MD_MTLO  = 7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } md_state_e;

   typedef enum logic [3:0] {
      OP_NONE,
      OP_DIV,
      OP_DIVU,
      OP_MULT,
      OP_MULTU,
      OP_MTHI,
      OP_MTLO,
      OP_MFHI,
      OP_MFLO
   } md_op_e;

   // With several MDop bits set, the highest-priority one wins.
   function automatic md_op_e md_decode(input logic [7:0] mdop);
      md_op_e op;
      op = OP_NONE;
      if (mdop[MD_DIV])        op = OP_DIV;
      else if (mdop[MD_DIVU])  op = OP_DIVU;
      else if (mdop[MD_MULT])  op = OP_MULT;
      else if (mdop[MD_MULTU]) op = OP_MULTU;
      else if (mdop[MD_MTHI])  op = OP_MTHI;
      else if (mdop[MD_MTLO])  op = OP_MTLO;
      else if (mdop[MD_MFHI])  op = OP_MFHI;
      else if (mdop[MD_MFLO])  op = OP_MFLO;
      return op;
   endfunction

endpackage

// File: rtl/md_div.sv
// md_div
//   32-step restoring divider, one quotient bit per clock.
//   clk, rst        : clock, async active-high reset
//   start           : load operands and clear the step counter
//   sgn             : treat operands as two's complement (sampled with start)
//   dividend/divisor: operands (sampled with start)
//   busy            : high while steps remain after the current one; it drops
//                     during the final step so the caller can leave its wait
//                     state in step with the last iteration
//   quotient        : final quotient (0xFFFFFFFF on divide by zero)
//   remainder       : final remainder (dividend on divide by zero)
module md_div (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        sgn,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic        busy,
   output logic [31:0] quotient,
   output logic [31:0] remainder
);

   logic        run_q, run_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] quo_q, quo_d;
   logic [31:0] dvs_q, dvs_d;
   logic [31:0] raw_a_q, raw_a_d;
   logic        neg_quo_q, neg_quo_d;
   logic        neg_rem_q, neg_rem_d;
   logic        dz_q, dz_d;

   logic [31:0] mag_a, mag_b;
   logic [32:0] rem_sh, diff;

   assign mag_a  = (sgn && dividend[31]) ? -dividend : dividend;
   assign mag_b  = (sgn && divisor[31])  ? -divisor  : divisor;
   // quo_q doubles as the dividend shift register: its top bit feeds the
   // partial remainder while quotient bits enter at the bottom.
   assign rem_sh = {rem_q, quo_q[31]};
   assign diff   = rem_sh - {1'b0, dvs_q};

   always_comb begin
      run_d     = run_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      raw_a_d   = raw_a_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      dz_d      = dz_q;
      if (start) begin
         run_d     = 1'b1;
         cnt_d     = 5'd0;
         rem_d     = 32'd0;
         quo_d     = mag_a;
         dvs_d     = mag_b;
         raw_a_d   = dividend;
         neg_quo_d = sgn && (dividend[31] ^ divisor[31]);
         neg_rem_d = sgn && dividend[31];
         dz_d      = (divisor == 32'd0);
      end else if (run_q) begin
         if (!diff[32]) begin
            rem_d = diff[31:0];
            quo_d = {quo_q[30:0], 1'b1};
         end else begin
            rem_d = rem_sh[31:0];
            quo_d = {quo_q[30:0], 1'b0};
         end
         cnt_d = cnt_q + 5'd1;
         if (cnt_q == 5'd31) run_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_q     <= 1'b0;
         cnt_q     <= 5'd0;
         rem_q     <= 32'd0;
         quo_q     <= 32'd0;
         dvs_q     <= 32'd0;
         raw_a_q   <= 32'd0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
      end else begin
         run_q     <= run_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvs_q     <= dvs_d;
         raw_a_q   <= raw_a_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         dz_q      <= dz_d;
      end
   end

   assign busy = run_q && (cnt_q != 5'd31);

   // Divide by zero bypasses the sign fix-up so signed and unsigned forms
   // both return all-ones / the raw dividend.
   assign quotient  = dz_q ? 32'hFFFF_FFFF : (neg_quo_q ? -quo_q : quo_q);
   assign remainder = dz_q ? raw_a_q       : (neg_rem_q ? -rem_q : rem_q);

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv
//   EX-stage multiply/divide unit with the architectural HI/LO registers.
//   clk, rst          : clock, async active-high reset
//   EX_in_MDop        : one-hot mul/div op from ID/EX (all zero = no op)
//   EX_in_RF_rs_data  : operand A (dividend, multiplicand, MTHI/MTLO source)
//   EX_in_RF_rt_data  : operand B (divisor, multiplier)
//   EX_MD_stall       : holds ID/EX while a multiply or divide is in flight
//   EX_MD_result      : MFHI/MFLO read data, 0 otherwise
//   EX_MD_HI/EX_MD_LO : HI/LO registers
//
//   state | meaning
//   IDLE  | accept a new op; MF*/MT* complete here without stall
//   MUL   | product registered, one extra stall cycle
//   DIV   | divider iterating, one quotient bit per cycle
//   DONE  | stall released, HI/LO written at cycle end
module ex_muldiv
   import ex_muldiv_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  EX_in_MDop,
   input  logic [31:0] EX_in_RF_rs_data,
   input  logic [31:0] EX_in_RF_rt_data,
   output logic        EX_MD_stall,
   output logic [31:0] EX_MD_result,
   output logic [31:0] EX_MD_HI,
   output logic [31:0] EX_MD_LO
);

   md_state_e   state_q, state_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [63:0] prod_q, prod_d;
   logic        is_div_q, is_div_d;

   md_op_e      op;
   logic [63:0] prod_s, prod_u;
   logic        div_start, div_sgn, div_busy;
   logic [31:0] div_quo, div_rem;

   assign op     = md_decode(EX_in_MDop);
   assign prod_s = $signed({{32{EX_in_RF_rs_data[31]}}, EX_in_RF_rs_data}) *
                   $signed({{32{EX_in_RF_rt_data[31]}}, EX_in_RF_rt_data});
   assign prod_u = {32'd0, EX_in_RF_rs_data} * {32'd0, EX_in_RF_rt_data};

   md_div u_md_div (
      .clk       (clk),
      .rst       (rst),
      .start     (div_start),
      .sgn       (div_sgn),
      .dividend  (EX_in_RF_rs_data),
      .divisor   (EX_in_RF_rt_data),
      .busy      (div_busy),
      .quotient  (div_quo),
      .remainder (div_rem)
   );

   // MDop is only looked at in IDLE: the op stays on the input while ID/EX
   // is held, and must not restart once the unit is busy or finishing.
   always_comb begin
      state_d      = state_q;
      hi_d         = hi_q;
      lo_d         = lo_q;
      prod_d       = prod_q;
      is_div_d     = is_div_q;
      EX_MD_stall  = 1'b0;
      EX_MD_result = 32'd0;
      div_start    = 1'b0;
      div_sgn      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            case (op)
               OP_DIV, OP_DIVU: begin
                  EX_MD_stall = 1'b1;
                  div_start   = 1'b1;
                  div_sgn     = (op == OP_DIV);
                  is_div_d    = 1'b1;
                  state_d     = ST_DIV;
               end
               OP_MULT: begin
                  EX_MD_stall = 1'b1;
                  prod_d      = prod_s;
                  is_div_d    = 1'b0;
                  state_d     = ST_MUL;
               end
               OP_MULTU: begin
                  EX_MD_stall = 1'b1;
                  prod_d      = prod_u;
                  is_div_d    = 1'b0;
                  state_d     = ST_MUL;
               end
               OP_MTHI: hi_d = EX_in_RF_rs_data;
               OP_MTLO: lo_d = EX_in_RF_rs_data;
               OP_MFHI: EX_MD_result = hi_q;
               OP_MFLO: EX_MD_result = lo_q;
               default: ;
            endcase
         end
         ST_MUL: begin
            EX_MD_stall = 1'b1;
            state_d     = ST_DONE;
         end
         ST_DIV: begin
            EX_MD_stall = 1'b1;
            if (!div_busy) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (is_div_q) begin
               hi_d = div_rem;
               lo_d = div_quo;
            end else begin
               hi_d = prod_q[63:32];
               lo_d = prod_q[31:0];
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
         prod_q   <= 64'd0;
         is_div_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         prod_q   <= prod_d;
         is_div_q <= is_div_d;
      end
   end

   assign EX_MD_HI = hi_q;
   assign EX_MD_LO = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;
   import ex_muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  mdop;
   logic [31:0] rs, rt;
   logic        stall;
   logic [31:0] result, hi, lo;

   always #5 clk = ~clk;

   ex_muldiv dut (
      .clk              (clk),
      .rst              (rst),
      .EX_in_MDop       (mdop),
      .EX_in_RF_rs_data (rs),
      .EX_in_RF_rt_data (rt),
      .EX_MD_stall      (stall),
      .EX_MD_result     (result),
      .EX_MD_HI         (hi),
      .EX_MD_LO         (lo)
   );

   typedef struct {
      string       name;
      int          stalls;
      logic [31:0] hi;
      logic [31:0] lo;
      logic [31:0] res;
   } exp_t;

   exp_t        sb[$];
   int          n_vec = 0;
   int          n_bad = 0;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   logic        pend = 1'b0;
   string       pend_nm;
   logic [31:0] pend_hi, pend_lo;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, req);
      end
   endtask

   // Monitor: a stall run ending, or a non-stalling op cycle, is one DUT
   // response; HI/LO are compared on the following cycle after the write.
   initial begin
      int   run;
      exp_t e;
      run = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            run  = 0;
            pend = 1'b0;
         end else begin
            if (pend) begin
               chk({pend_nm, ".hi"}, hi, pend_hi);
               chk({pend_nm, ".lo"}, lo, pend_lo);
               pend = 1'b0;
            end
            if (stall) begin
               run++;
            end else if (run > 0 || mdop != 8'd0) begin
               if (sb.size() == 0) begin
                  n_vec++;
                  n_bad++;
                  $display("FAIL unexpected_response: got stall run %0d, expected nothing", run);
               end else begin
                  e = sb.pop_front();
                  chk({e.name, ".stall_cycles"}, 32'(run), 32'(e.stalls));
                  chk({e.name, ".result"}, result, e.res);
                  pend    = 1'b1;
                  pend_nm = e.name;
                  pend_hi = e.hi;
                  pend_lo = e.lo;
               end
               run = 0;
            end
         end
      end
   end

   task automatic wait_ready(input string nm);
      int n;
      n = 0;
      @(negedge clk);
      while (stall && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         n_vec++;
         n_bad++;
         $display("FAIL %s.timeout: stall still %b after %0d cycles, expected release", nm, stall, n);
      end
      @(posedge clk);
      #1;
      mdop = 8'd0;
   endtask

   task automatic issue(input string nm, input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int stalls, input logic [31:0] e_hi,
                        input logic [31:0] e_lo, input logic [31:0] e_res);
      exp_t e;
      mdop = op;
      rs   = a;
      rt   = b;
      m_hi = e_hi;
      m_lo = e_lo;
      e.name   = nm;
      e.stalls = stalls;
      e.hi     = e_hi;
      e.lo     = e_lo;
      e.res    = e_res;
      sb.push_back(e);
      wait_ready(nm);
   endtask

   function automatic logic [7:0] bitv(input int pos);
      logic [7:0] v;
      v = 8'd0;
      v[pos] = 1'b1;
      return v;
   endfunction

   initial begin
      rst  = 1'b0;
      mdop = 8'd0;
      rs   = 32'd0;
      rt   = 32'd0;
      #1 rst = 1'b1;
      #1;
      chk("reset.stall", 32'(stall), 32'd0);
      chk("reset.hi", hi, 32'd0);
      chk("reset.lo", lo, 32'd0);
      chk("reset.result", result, 32'd0);
      @(negedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      #1;

      issue("divu_100_7",   bitv(MD_DIVU), 32'd100, 32'd7, 33, 32'd2, 32'd14, 32'd0);
      issue("div_m7_2",     bitv(MD_DIV), 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd0);
      issue("mult_m1_2",    bitv(MD_MULT), 32'hFFFF_FFFF, 32'd2, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd0);
      issue("multu_ff_2",   bitv(MD_MULTU), 32'hFFFF_FFFF, 32'd2, 2, 32'd1, 32'hFFFF_FFFE, 32'd0);
      issue("divu_by_zero", bitv(MD_DIVU), 32'h0000_1234, 32'd0, 33, 32'h0000_1234, 32'hFFFF_FFFF, 32'd0);
      issue("mthi",         bitv(MD_MTHI), 32'hA5A5_A5A5, 32'd0, 0, 32'hA5A5_A5A5, m_lo, 32'd0);
      issue("mfhi",         bitv(MD_MFHI), 32'd0, 32'd0, 0, m_hi, m_lo, 32'hA5A5_A5A5);
      issue("div_100_m7",   bitv(MD_DIV), 32'd100, 32'hFFFF_FFF9, 33, 32'd2, 32'hFFFF_FFF2, 32'd0);
      issue("mflo_after",   bitv(MD_MFLO), 32'd0, 32'd0, 0, m_hi, m_lo, 32'hFFFF_FFF2);
      issue("div_by_zero",  bitv(MD_DIV), 32'hFFFF_FFF0, 32'd0, 33, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd0);
      issue("div_ovf",      bitv(MD_DIV), 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000, 32'd0);
      issue("div_m100_7",   bitv(MD_DIV), 32'hFFFF_FF9C, 32'd7, 33, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 32'd0);
      issue("mult_7_m3",    bitv(MD_MULT), 32'd7, 32'hFFFF_FFFD, 2, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 32'd0);
      issue("mtlo",         bitv(MD_MTLO), 32'h0BAD_F00D, 32'd0, 0, m_hi, 32'h0BAD_F00D, 32'd0);
      issue("mflo",         bitv(MD_MFLO), 32'd0, 32'd0, 0, m_hi, m_lo, 32'h0BAD_F00D);
      issue("prio_divu",    bitv(MD_DIVU) | bitv(MD_MULT) | bitv(MD_MFLO), 32'd20, 32'd6,
            33, 32'd2, 32'd3, 32'd0);
      issue("prio_mthi",    bitv(MD_MTHI) | bitv(MD_MTLO) | bitv(MD_MFHI), 32'h1234_5678, 32'd0,
            0, 32'h1234_5678, m_lo, 32'd0);
      issue("prio_mult",    bitv(MD_MULT) | bitv(MD_MULTU), 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            2, 32'd0, 32'd1, 32'd0);
      issue("multu_carry",  bitv(MD_MULTU), 32'h0001_0000, 32'h0001_0000, 2, 32'd1, 32'd0, 32'd0);

      // Abort a divide part-way through with a reset pulse.
      mdop = bitv(MD_DIVU);
      rs   = 32'd500;
      rt   = 32'd3;
      repeat (12) @(negedge clk);
      #1;
      chk("rst_mid_div.pre_stall", 32'(stall), 32'd1);
      #1;
      rst  = 1'b1;
      mdop = 8'd0;
      #1;
      chk("rst_mid_div.stall", 32'(stall), 32'd0);
      chk("rst_mid_div.hi", hi, 32'd0);
      chk("rst_mid_div.lo", lo, 32'd0);
      chk("rst_mid_div.result", result, 32'd0);
      @(negedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
      m_hi = 32'd0;
      m_lo = 32'd0;
      issue("divu_9_3",     bitv(MD_DIVU), 32'd9, 32'd3, 33, 32'd0, 32'd3, 32'd0);
      issue("mflo_9_3",     bitv(MD_MFLO), 32'd0, 32'd0, 0, m_hi, m_lo, 32'd3);

      repeat (3) @(posedge clk);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port EX_in_MDop  input  8  one-hot mul/div op from the ID/EX register: MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO; all-zero = no op.
REQ-004 SHALL have port EX_in_RF_rs_data  input  32  operand A (dividend / multiplicand / MTHI and MTLO source).
REQ-005 SHALL have port EX_in_RF_rt_data  input  32  operand B (divisor / multiplier).
REQ-006 SHALL have port EX_MD_stall  output  1  holds the ID/EX register (drives EX_stall) while an op is in progress.
REQ-007 SHALL have port EX_MD_result  output  32  MFHI/MFLO read data; 0 for any other op.
REQ-008 SHALL have ports EX_MD_HI and EX_MD_LO  output  32 each  architectural HI/LO registers.

Function
REQ-009 SHALL implement states IDLE, MUL, DIV, DONE.
REQ-010 SHALL, in IDLE with MULT/MULTU, assert stall, register the 64-bit signed/unsigned product, and go to MUL.
REQ-011 SHALL, in MUL, assert stall for exactly one cycle, then go to DONE.
REQ-012 SHALL, in IDLE with DIV/DIVU, assert stall, load operand magnitudes (signed) or raw values (unsigned), clear the 5-bit iteration counter, and go to DIV.
REQ-013 SHALL, in DIV, perform one restoring-division step per cycle with stall asserted, and go to DONE after exactly 32 steps (counter 31 -> wrap).
REQ-014 SHALL, in DONE, deassert stall, write HI=remainder/product[63:32] and LO=quotient/product[31:0] at the cycle end, and return to IDLE.
REQ-015 SHALL produce total stall cycles of 2 for MULT/MULTU and 33 for DIV/DIVU.
REQ-016 SHALL, for signed divide, negate the quotient when rs[31]^rt[31] and give the remainder the sign of rs.
REQ-017 SHALL, on divide by zero (signed or unsigned), give LO=0xFFFFFFFF, HI=rs, with the same 33-cycle latency.
REQ-018 SHALL, in IDLE, complete MFHI/MFLO combinationally (EX_MD_result = HI/LO) with no stall.
REQ-019 SHALL, in IDLE, complete MTHI/MTLO with no stall, writing rs into HI/LO at the cycle end.
REQ-020 SHALL ignore EX_in_MDop in MUL, DIV and DONE, so the held op is never restarted.
REQ-021 SHALL, for a mul/div op arriving the cycle after DONE, start it normally from IDLE.
REQ-022 SHALL, if more than one MDop bit is set, act on the highest-priority bit in the order DIV, DIVU, MULT, MULTU, MTHI, MTLO, MFHI, MFLO.
REQ-023 SHALL make an MFHI/MFLO issued immediately after DONE see the newly written HI/LO.

Reset
REQ-024 SHALL, on rst assertion at any time (including mid-divide), immediately force the state to IDLE, stall to 0, HI/LO/result to 0, and the counter and partial remainder/quotient to 0.
REQ-025 SHALL resume operation on the first rising clk edge after rst deasserts.

Structure
REQ-026 SHALL take the MDop bit positions and state encodings from shared defines in mycpu.h, also used by the decoder.
REQ-027 SHALL place the 32-step iterative divider in a sub-module md_div (start, signed flag, operands in; busy, quotient, remainder out); the multiplier and the HI/LO control stay in ex_muldiv.

Verification
REQ-028 SHALL verify DIVU rs=100, rt=7 -> stall high 33 cycles, then LO=14, HI=2.
REQ-029 SHALL verify DIV rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-030 SHALL verify MULT 0xFFFFFFFF x 2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE; MULTU with the same operands -> HI=1, LO=0xFFFFFFFE; stall 2 cycles each.
REQ-031 SHALL verify DIVU rs=0x1234, rt=0 -> LO=0xFFFFFFFF, HI=0x1234.
REQ-032 SHALL verify MTHI 0xA5A5A5A5 followed by MFHI -> no stall, EX_MD_result=0xA5A5A5A5; DIV immediately followed by MFLO -> MFLO returns the new quotient.
REQ-033 SHALL verify rst pulsed at DIV step 10 -> stall drops immediately, HI=LO=0; a subsequent DIVU 9/3 gives LO=3, HI=0.
